bus_demux4: RTL

Four-way bus distributor for the expression-solver datapath: the write-side counterpart of the 4:1 `mux`. It takes one `WIDTH`-bit word from the shared result bus and steers it by a 2-bit select into one of four single-entry holding registers. Each register has its own valid/ack handshake to its consumer. A destination that is still occupied back-pressures the bus through `in_ready`. A wrapping counter records how many words have been delivered.

---
 rtl/bus_demux4_if.sv | 22 ++
 rtl/bus_demux4.sv | 41 ++++
 2 files changed

// File: rtl/bus_demux4_if.sv
// bus_demux4_if: producer-side bus and the four consumer handshakes of the 1:4 distributor
interface bus_demux4_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ack;
  logic [7:0]       delivered;
  modport master (
    output in_valid, in_data, sel, out_ack,
    input  in_ready, out0, out1, out2, out3, out_valid, delivered
  );
  modport slave (
    input  in_valid, in_data, sel, out_ack,
    output in_ready, out0, out1, out2, out3, out_valid, delivered
  );
endinterface

// File: rtl/bus_demux4.sv
// bus_demux4: steers one bus word by sel into one of four single-entry handshaked slots
module bus_demux4 #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  bus_demux4_if.slave bus
);
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q, valid_d, hit;
  logic [7:0]       delivered_q, delivered_d;
  logic             accept;
  // an acked full slot frees up in the same cycle, so it can be refilled without a bubble
  assign bus.in_ready = !valid_q[bus.sel] | bus.out_ack[bus.sel];
  assign accept = bus.in_valid & bus.in_ready;
  always_comb begin
    delivered_d = delivered_q + {7'd0, accept};
    for (int i = 0; i < 4; i++) begin
      hit[i]     = accept && (bus.sel == 2'(i));
      valid_d[i] = hit[i] | (valid_q[i] & ~bus.out_ack[i]);
      data_d[i]  = hit[i] ? bus.in_data : data_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q      <= '{default: '0};
      valid_q     <= '0;
      delivered_q <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      delivered_q <= delivered_d;
    end
  assign bus.out0      = data_q[0];
  assign bus.out1      = data_q[1];
  assign bus.out2      = data_q[2];
  assign bus.out3      = data_q[3];
  assign bus.out_valid = valid_q;
  assign bus.delivered = delivered_q;
endmodule
